// File: rtl/uart_block_tx.sv
// Streams one NUM_BYTES ciphertext block, byte by byte, into a UART transmitter.
// Every output is registered and follows the next-state decode, so each output settles one edge after the decision.
module uart_block_tx #(
  parameter int NUM_BYTES = 16,
  parameter int GAP_CLKS  = 0,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   block_valid,
  input  logic [8*NUM_BYTES-1:0] block_data,
  output logic                   block_ready,
  output logic                   tx_drive,
  output logic [7:0]             tx_byte_in,
  input  logic                   tx_active,
  input  logic                   tx_done,
  output logic                   busy,
  output logic                   block_sent
);

  localparam int DW    = 8 * NUM_BYTES;
  localparam int CNT_W = $clog2(NUM_BYTES + 1);
  localparam int GAP_W = (GAP_CLKS > 0) ? $clog2(GAP_CLKS + 1) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    WAIT_DONE = 3'd2,
    GAP       = 3'd3,
    FINISH    = 3'd4
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [DW-1:0]    shreg;
  logic [DW-1:0]    shreg_next;
  logic [CNT_W-1:0] byte_cnt;
  logic [CNT_W-1:0] byte_cnt_next;
  logic [GAP_W-1:0] gap_cnt;
  logic [GAP_W-1:0] gap_cnt_next;
  logic             bad_state;
  logic             ready_next;
  logic             drive_next;
  logic             busy_next;
  logic             sent_next;
  logic [7:0]       byte_next;

  // Transmitter activity is status only; sequencing relies on tx_done alone.
  logic unused_inputs;
  assign unused_inputs = tx_active;

  function automatic logic [7:0] head_byte(input logic [DW-1:0] v);
    if (MSB_FIRST) begin
      head_byte = v[DW-1 -: 8];
    end else begin
      head_byte = v[7:0];
    end
  endfunction

  function automatic logic [DW-1:0] advance(input logic [DW-1:0] v);
    if (MSB_FIRST) begin
      advance = v << 8;
    end else begin
      advance = v >> 8;
    end
  endfunction

  // Next-state, datapath and next-output decode.
  always_comb begin
    state_next    = state;
    shreg_next    = shreg;
    byte_cnt_next = byte_cnt;
    gap_cnt_next  = gap_cnt;
    bad_state     = 1'b0;
    case (state)
      IDLE: begin
        if (block_valid) begin
          shreg_next    = block_data;
          byte_cnt_next = '0;
          state_next    = LOAD;
        end else begin
          state_next = IDLE;
        end
      end
      LOAD: begin
        state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tx_done) begin
          byte_cnt_next = byte_cnt + CNT_W'(1);
          if (byte_cnt_next == CNT_W'(NUM_BYTES)) begin
            state_next = FINISH;
          end else begin
            shreg_next = advance(shreg);
            if (GAP_CLKS > 0) begin
              gap_cnt_next = '0;
              state_next   = GAP;
            end else begin
              state_next = LOAD;
            end
          end
        end else begin
          state_next = WAIT_DONE;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_W'(GAP_CLKS - 1)) begin
          state_next = LOAD;
        end else begin
          gap_cnt_next = gap_cnt + GAP_W'(1);
        end
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        bad_state     = 1'b1;
        state_next    = IDLE;
        shreg_next    = '0;
        byte_cnt_next = '0;
        gap_cnt_next  = '0;
      end
    endcase

    // A corrupted state recovers to IDLE with every output at its reset value.
    if (bad_state) begin
      ready_next = 1'b0;
      drive_next = 1'b0;
      busy_next  = 1'b0;
      sent_next  = 1'b0;
      byte_next  = 8'h00;
    end else begin
      ready_next = (state_next == IDLE);
      drive_next = (state_next == LOAD);
      busy_next  = (state_next != IDLE);
      sent_next  = (state_next == FINISH);
      if (state_next == LOAD) begin
        byte_next = head_byte(shreg_next);
      end else begin
        byte_next = tx_byte_in;
      end
    end
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      shreg       <= '0;
      byte_cnt    <= '0;
      gap_cnt     <= '0;
      block_ready <= 1'b0;
      tx_drive    <= 1'b0;
      tx_byte_in  <= 8'h00;
      busy        <= 1'b0;
      block_sent  <= 1'b0;
    end else begin
      state       <= state_next;
      shreg       <= shreg_next;
      byte_cnt    <= byte_cnt_next;
      gap_cnt     <= gap_cnt_next;
      block_ready <= ready_next;
      tx_drive    <= drive_next;
      tx_byte_in  <= byte_next;
      busy        <= busy_next;
      block_sent  <= sent_next;
    end
  end

endmodule

// File: tb/tb_uart_block_tx.sv
// Bench for uart_block_tx: three instances (MSB-first, LSB-first, MSB-first with a 3-clock gap)
// share one UART model that answers each tx_drive with tx_done ten cycles later.
module tb_uart_block_tx;

  logic         clk;
  logic         reset;
  logic         block_valid [3];
  logic [127:0] block_data  [3];
  logic         block_ready [3];
  logic         tx_drive    [3];
  logic [7:0]   tx_byte_in  [3];
  logic         busy        [3];
  logic         block_sent  [3];
  bit           spur        [3];
  bit           model_done  [3];
  bit           model_active[3];
  bit           prev_busy   [3];

  int           pend    [3];
  int           drives  [3];
  int           got_n   [3];
  int           sents   [3];
  int           viol    [3];
  int           gap_min [3];
  int           gap_max [3];
  int           done_cyc[3];
  int           cyc;
  logic [7:0]   held    [3];
  logic [7:0]   got     [3][64];

  int n_checks;
  int n_fail;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    uart_block_tx #(
      .NUM_BYTES(16),
      .GAP_CLKS ((g == 2) ? 3 : 0),
      .MSB_FIRST((g == 1) ? 1'b0 : 1'b1)
    ) dut (
      .clk        (clk),
      .reset      (reset),
      .block_valid(block_valid[g]),
      .block_data (block_data[g]),
      .block_ready(block_ready[g]),
      .tx_drive   (tx_drive[g]),
      .tx_byte_in (tx_byte_in[g]),
      .tx_active  (model_active[g]),
      .tx_done    (model_done[g] | spur[g]),
      .busy       (busy[g]),
      .block_sent (block_sent[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // UART model and per-block monitor; statistics restart whenever busy rises.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 3; i++) begin
      prev_busy[i]    <= busy[i];
      model_done[i]   <= (pend[i] == 1);
      model_active[i] <= (pend[i] > 1) || tx_drive[i];
      if (pend[i] == 1) done_cyc[i] <= cyc;
      if (tx_drive[i]) begin
        pend[i] <= 10;
        held[i] <= tx_byte_in[i];
      end else if (pend[i] > 0) begin
        pend[i] <= pend[i] - 1;
      end
      if (busy[i] && !prev_busy[i]) begin
        got_n[i]   <= tx_drive[i] ? 1 : 0;
        drives[i]  <= tx_drive[i] ? 1 : 0;
        sents[i]   <= 0;
        gap_min[i] <= 1000;
        gap_max[i] <= 0;
        if (tx_drive[i]) got[i][0] <= tx_byte_in[i];
      end else begin
        if (tx_drive[i]) begin
          got[i][6'(got_n[i])] <= tx_byte_in[i];
          got_n[i]  <= got_n[i] + 1;
          drives[i] <= drives[i] + 1;
          if (drives[i] > 0) begin
            gap_min[i] <= ((cyc - done_cyc[i]) < gap_min[i]) ? (cyc - done_cyc[i]) : gap_min[i];
            gap_max[i] <= ((cyc - done_cyc[i]) > gap_max[i]) ? (cyc - done_cyc[i]) : gap_max[i];
          end
        end
        if (block_sent[i]) sents[i] <= sents[i] + 1;
      end
      viol[i] <= viol[i]
               + ((tx_drive[i] && pend[i] == 1) ? 1 : 0)
               + ((busy[i] && pend[i] > 0 && !tx_drive[i] && tx_byte_in[i] != held[i]) ? 1 : 0)
               + ((busy[i] && block_ready[i]) ? 1 : 0);
    end
  end

  function automatic bit msb_of(input int i);
    return (i != 1);
  endfunction

  function automatic int gap_of(input int i);
    return (i == 2) ? 3 : 0;
  endfunction

  // Reference: bytes in transmission order, packed first byte at the top.
  function automatic logic [127:0] expect_order(input int i, input logic [127:0] d);
    logic [127:0] r;
    logic [7:0]   b;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      if (msb_of(i)) b = 8'(d >> (8 * (15 - k)));
      else           b = 8'(d >> (8 * k));
      r[127 - 8*k -: 8] = b;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start_block(input int i, input logic [127:0] d);
    int t;
    t = 0;
    while (block_ready[i] !== 1'b1 && t < 200) begin
      tick();
      t++;
    end
    check($sformatf("ready_wait[%0d]", i), 128'(block_ready[i]), 128'(1));
    block_valid[i] = 1'b1;
    block_data[i]  = d;
    tick();
    block_valid[i] = 1'b0;
    block_data[i]  = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic finish_block(input int i, input logic [127:0] d, input string tag);
    int t;
    logic [127:0] gv;
    t = 0;
    while (block_sent[i] !== 1'b1 && t < 1000) begin
      tick();
      t++;
    end
    check({tag, " block_sent"}, 128'(block_sent[i]), 128'(1));
    check({tag, " ready/busy in finish"}, 128'({block_ready[i], busy[i]}), 128'(2'b01));
    gv = '0;
    for (int k = 0; k < 16; k++) gv[127 - 8*k -: 8] = got[i][6'(k)];
    check({tag, " byte order"}, gv, expect_order(i, d));
    check({tag, " drive count"}, 128'(drives[i]), 128'(16));
    check({tag, " captured bytes"}, 128'(got_n[i]), 128'(16));
    check({tag, " sent pulses"}, 128'(sents[i]), 128'(1));
    check({tag, " gap min"}, 128'(gap_min[i]), 128'(gap_of(i) + 1));
    check({tag, " gap max"}, 128'(gap_max[i]), 128'(gap_of(i) + 1));
    check({tag, " protocol violations"}, 128'(viol[i]), 128'(0));
    tick();
    check({tag, " ready after finish"}, 128'({block_ready[i], busy[i], block_sent[i]}), 128'(3'b100));
  endtask

  typedef struct {
    int           inst;
    logic [127:0] data;
    logic [7:0]   first;
    logic [7:0]   last;
  } vec_t;

  localparam logic [127:0] KAT = 128'h00112233445566778899AABBCCDDEEFF;

  vec_t vecs[4];

  initial begin
    int t;
    int ri;
    logic [127:0] a;
    logic [127:0] b;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      block_valid[i] = 1'b0;
      block_data[i]  = '0;
      spur[i]        = 1'b0;
    end
    vecs[0] = '{0, KAT, 8'h00, 8'hFF};
    vecs[1] = '{1, KAT, 8'hFF, 8'h00};
    vecs[2] = '{2, KAT, 8'h00, 8'hFF};
    vecs[3] = '{1, 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0, 8'hF0, 8'h0F};

    repeat (3) tick();
    for (int i = 0; i < 3; i++)
      check($sformatf("reset outputs[%0d]", i),
            128'({block_ready[i], tx_drive[i], busy[i], block_sent[i], tx_byte_in[i]}), 128'(0));
    reset = 1'b0;
    tick();
    for (int i = 0; i < 3; i++)
      check($sformatf("ready after reset[%0d]", i), 128'({block_ready[i], busy[i]}), 128'(2'b10));

    // Directed vectors, including the known-answer block in every configuration.
    for (int v = 0; v < 4; v++) begin
      start_block(vecs[v].inst, vecs[v].data);
      check($sformatf("vec%0d first drive", v), 128'({tx_drive[vecs[v].inst], busy[vecs[v].inst]}), 128'(2'b11));
      finish_block(vecs[v].inst, vecs[v].data, $sformatf("vec%0d", v));
      check($sformatf("vec%0d first byte", v), 128'(got[vecs[v].inst][0]), 128'(vecs[v].first));
      check($sformatf("vec%0d last byte", v), 128'(got[vecs[v].inst][15]), 128'(vecs[v].last));
    end

    // block_valid while busy must be ignored.
    a = {$urandom(), $urandom(), $urandom(), $urandom()};
    b = ~a;
    start_block(0, a);
    t = 0;
    while (drives[0] < 3 && t < 200) begin tick(); t++; end
    for (int p = 0; p < 3; p++) begin
      block_valid[0] = 1'b1;
      block_data[0]  = b;
      check($sformatf("ready low while busy %0d", p), 128'(block_ready[0]), 128'(0));
      tick();
      block_valid[0] = 1'b0;
      tick();
    end
    finish_block(0, a, "busy_ignore");

    // Back-to-back: valid held high is taken in the first IDLE cycle after FINISH.
    a = {$urandom(), $urandom(), $urandom(), $urandom()};
    b = {$urandom(), $urandom(), $urandom(), $urandom()};
    start_block(1, a);
    block_valid[1] = 1'b1;
    block_data[1]  = b;
    finish_block(1, a, "b2b_first");
    check("b2b idle ready", 128'(block_ready[1]), 128'(1));
    tick();
    check("b2b immediate load", 128'({tx_drive[1], busy[1], block_ready[1]}), 128'(3'b110));
    block_valid[1] = 1'b0;
    finish_block(1, b, "b2b_second");

    // Reset just after the sixth byte is driven; the in-flight tx_done arrives late.
    a = {$urandom(), $urandom(), $urandom(), $urandom()};
    start_block(0, a);
    t = 0;
    while (drives[0] < 6 && t < 400) begin tick(); t++; end
    check("reached byte 5", 128'(drives[0]), 128'(6));
    reset = 1'b1;
    tick();
    check("mid-block reset", 128'({tx_drive[0], busy[0], block_ready[0], tx_byte_in[0]}), 128'(0));
    reset = 1'b0;
    tick();
    check("idle after reset", 128'({block_ready[0], busy[0]}), 128'(2'b10));
    repeat (12) tick();
    check("late done ignored", 128'({drives[0], 1'b0, busy[0], tx_drive[0]}), 128'({32'd6, 3'b000}));
    b = {$urandom(), $urandom(), $urandom(), $urandom()};
    start_block(0, b);
    finish_block(0, b, "after_reset");

    // Spurious tx_done in IDLE and in GAP.
    spur[2] = 1'b1;
    tick();
    spur[2] = 1'b0;
    tick();
    check("spur idle", 128'({busy[2], tx_drive[2], block_ready[2]}), 128'(3'b001));
    a = {$urandom(), $urandom(), $urandom(), $urandom()};
    start_block(2, a);
    t = 0;
    while (!(model_done[2] && drives[2] == 2) && t < 200) begin tick(); t++; end
    check("second done seen", 128'(model_done[2]), 128'(1));
    tick();
    spur[2] = 1'b1;
    tick();
    spur[2] = 1'b0;
    finish_block(2, a, "spur_gap");

    // Random blocks against the reference ordering.
    for (int r = 0; r < 5; r++) begin
      ri = int'($urandom_range(2, 0));
      a  = {$urandom(), $urandom(), $urandom(), $urandom()};
      start_block(ri, a);
      finish_block(ri, a, $sformatf("rand%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_block_tx.md
UART_BLOCK_TX -- requirements
Module: uart_block_tx

Interface
REQ-001: Parameter NUM_BYTES, default 16, number of bytes per block (AES-128 block = 16).
REQ-002: Parameter GAP_CLKS, default 0, idle clocks inserted between a tx_done and the next tx_drive.
REQ-003: Parameter MSB_FIRST, default 1; 1 = block_data[127:120] sent first, 0 = block_data[7:0] sent first.
REQ-004: clk  input  1  single clock; all logic on posedge.
REQ-005: reset  input  1  synchronous, active-high reset.
REQ-006: block_valid  input  1  upstream (AES core) offers a block.
REQ-007: block_data  input  8*NUM_BYTES  ciphertext block; sampled only on handshake.
REQ-008: block_ready  output  1  block accepted when block_valid && block_ready on a clk edge.
REQ-009: tx_drive  output  1  one-cycle start pulse to the UART transmitter.
REQ-010: tx_byte_in  output  8  byte presented to the UART transmitter.
REQ-011: tx_active  input  1  UART transmitter activity status; informational only, not used for sequencing.
REQ-012: tx_done  input  1  one-cycle pulse from the UART transmitter at end of stop bit.
REQ-013: busy  output  1  high from handshake until block_sent.
REQ-014: block_sent  output  1  one-cycle pulse after the last byte's tx_done.

Function
REQ-015: State machine SHALL have states IDLE, LOAD, WAIT_DONE, GAP, FINISH.
REQ-016: IDLE: block_ready=1; on block_valid, SHALL capture block_data into a shift register, clear byte counter, go to LOAD.
REQ-017: LOAD: tx_byte_in SHALL equal the current byte; tx_drive=1 for exactly this one cycle; next state WAIT_DONE.
REQ-018: tx_byte_in SHALL be registered and held stable from LOAD until tx_done is observed.
REQ-019: WAIT_DONE: on tx_done, increment byte counter; if counter reaches NUM_BYTES go to FINISH, else shift register advances one byte and go to GAP (GAP_CLKS>0) or LOAD (GAP_CLKS=0).
REQ-020: GAP: count GAP_CLKS cycles, then go to LOAD; counter cleared on entry.
REQ-021: FINISH: block_sent=1 for one cycle; next state IDLE; block_ready rises the cycle after FINISH.
REQ-022: Minimum spacing: tx_drive SHALL never assert in the same cycle tx_done is sampled; earliest re-drive is the cycle after tx_done.
REQ-023: block_ready SHALL be 0 in every state except IDLE; block_valid outside IDLE SHALL be ignored and block_data not sampled.
REQ-024: tx_done received in IDLE, LOAD, GAP or FINISH SHALL be ignored (no counter change).
REQ-025: Byte counter width SHALL be $clog2(NUM_BYTES+1); no wrap; exactly NUM_BYTES tx_drive pulses per accepted block.
REQ-026: Back-to-back blocks: block_valid held high SHALL be accepted in the first IDLE cycle after FINISH.
REQ-027: busy SHALL be 1 in LOAD, WAIT_DONE, GAP, FINISH, 0 in IDLE.
REQ-028: Unreachable state encodings SHALL return to IDLE with all outputs at reset values.

Reset
REQ-029: Reset SHALL force state IDLE, block_ready=0 during reset and 1 in the first cycle after release, tx_drive=0, tx_byte_in=8'h00, busy=0, block_sent=0, counters cleared.
REQ-030: Reset mid-block SHALL abandon remaining bytes; a byte already handed to the UART completes, and its tx_done after reset SHALL be ignored.

Verification
REQ-031: Block 0x00112233445566778899AABBCCDDEEFF, MSB_FIRST=1, UART model tx_done 10 cycles after drive -> tx_byte_in sequence 00,11,...,FF; 16 tx_drive pulses; one block_sent.
REQ-032: Same block, MSB_FIRST=0 -> sequence FF,EE,...,00.
REQ-033: GAP_CLKS=3 -> exactly 3 idle cycles + LOAD between each tx_done and next tx_drive (tx_drive 4 cycles after tx_done).
REQ-034: block_valid pulsed while busy with different data -> ignored; transmitted bytes match first block only; block_ready=0 throughout.
REQ-035: Reset asserted after byte 5's tx_drive -> next cycle IDLE, tx_drive=0, busy=0; late tx_done ignored; new block then sent in full from byte 0.
REQ-036: Spurious tx_done in IDLE and GAP -> no byte counter change, no extra tx_drive, byte order intact.
